// File: rtl/amiga_daug_pkg.sv
// Shared types and address-decode helpers for the A1000-style daughterboard controller.
// Region decode is purely combinational; the controller classifies each cycle exactly once.
package amiga_daug_pkg;

    typedef enum logic [1:0] {REG_NONE, REG_BOOT, REG_LOCK, REG_WOM} region_t;

    typedef enum logic [2:0] {ST_IDLE, ST_DECODE, ST_WAIT, ST_ACK, ST_TERM} state_t;

    localparam int REGION_LG2   = 18;
    localparam int REGION_COUNT = 1 << (24 - REGION_LG2);

    // Overlay image occupies the bottom 2^lg2 bytes when OVL is set.
    function automatic logic in_overlay(input logic [22:0] a, input int ovl_lg2);
        return (({a, 1'b0} >> ovl_lg2) == 24'd0);
    endfunction

    // WOM window is the top `banks` 256KB regions, ending at $FFFFFF.
    function automatic logic in_wom(input logic [5:0] idx, input int banks);
        return (idx >= 6'(REGION_COUNT - banks));
    endfunction

    function automatic logic [1:0] wom_bank(input logic [1:0] bank_bits, input int banks);
        return bank_bits & 2'(banks - 1);
    endfunction

    function automatic region_t decode_region(input logic [22:0] a, input logic ovl,
                                              input int ovl_lg2, input logic [5:0] lock_idx,
                                              input int banks);
        if (ovl && in_overlay(a, ovl_lg2)) return REG_BOOT;
        if (a[22:17] == lock_idx)           return REG_LOCK;
        if (in_wom(a[22:17], banks))        return REG_WOM;
        return REG_NONE;
    endfunction

endpackage

// File: rtl/amiga_bus_sync.sv
// Two-flop synchroniser for the asynchronous 68000 bus strobes.
// Resets to all-ones so negated active-low strobes are seen during and after reset.
module amiga_bus_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/amiga_daug_wom_ctrl.sv
// Boot ROM / writable-once Kickstart memory bus slave with programmable-wait DTACK and write lock.
//   state  | meaning
//   IDLE   | no cycle; waiting for synced _AS low
//   DECODE | classify region once, latch selects and load wait counter
//   WAIT   | countdown, frozen while xrdy is low
//   ACK    | first DTACK cycle; lock write takes effect here
//   TERM   | DTACK held (silent if unmapped) until synced _AS negates
module amiga_daug_wom_ctrl
    import amiga_daug_pkg::*;
#(
    parameter int          WOM_BANKS    = 2,
    parameter int          WAIT_STATES  = 2,
    parameter logic [23:0] LOCK_BASE    = 24'hF40000,
    parameter int          OVL_SIZE_LG2 = 18
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [22:0]          a,
    input  logic                 as_n,
    input  logic                 uds_n,
    input  logic                 lds_n,
    input  logic                 prw,
    input  logic                 ovl,
    input  logic                 ovr_n,
    input  logic                 xrdy,
    output logic                 dtack_n,
    output logic                 dtack_oe,
    output logic                 rome_n,
    output logic [WOM_BANKS-1:0] wom_cs_n,
    output logic [1:0]           wom_we_n,
    output logic                 wom_oe_n,
    output logic                 wom_locked
);

    if (!(WOM_BANKS == 1 || WOM_BANKS == 2 || WOM_BANKS == 4)) begin : g_bad_banks
        $error("WOM_BANKS must be 1, 2 or 4");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
        $error("WAIT_STATES must be 0..15");
    end
    if (LOCK_BASE[17:0] != 18'd0) begin : g_bad_lock_align
        $error("LOCK_BASE must be 256KB aligned");
    end
    if (in_wom(LOCK_BASE[23:18], WOM_BANKS)) begin : g_bad_lock_overlap
        $error("LOCK_BASE lies inside the WOM window");
    end

    logic [2:0] sync_q;
    logic       as_s, uds_s, lds_s;

    amiga_bus_sync #(.WIDTH(3)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({as_n, uds_n, lds_n}),
        .q     (sync_q)
    );
    assign {as_s, uds_s, lds_s} = sync_q;

    state_t     state, state_nx;
    region_t    decoded, sel_region;
    logic [3:0] cnt;
    logic       sel_write, sel_locked, locked, dtack_rel;
    logic [1:0] sel_lanes, sel_bank;

    assign decoded = ovr_n ? decode_region(a, ovl, OVL_SIZE_LG2, LOCK_BASE[23:18], WOM_BANKS)
                           : REG_NONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (!as_s) state_nx = ST_DECODE;
            ST_DECODE: begin
                if (as_s)                    state_nx = ST_IDLE;
                else if (decoded == REG_NONE) state_nx = ST_TERM;
                else                         state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (as_s)                         state_nx = ST_IDLE;
                else if (xrdy && cnt == 4'd0)     state_nx = ST_ACK;
            end
            ST_ACK:    state_nx = ST_TERM;
            ST_TERM:   if (as_s) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 4'd0;
            sel_region <= REG_NONE;
            sel_write  <= 1'b0;
            sel_lanes  <= 2'b11;
            sel_bank   <= 2'd0;
            sel_locked <= 1'b0;
            locked     <= 1'b0;
            dtack_rel  <= 1'b0;
        end else begin
            if (state == ST_DECODE) begin
                cnt        <= 4'(WAIT_STATES);
                sel_region <= decoded;
                sel_write  <= !prw;
                sel_lanes  <= {uds_s, lds_s};
                sel_bank   <= wom_bank(a[18:17], WOM_BANKS);
                sel_locked <= locked;
            end else if (state == ST_WAIT && xrdy && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (state == ST_WAIT && state_nx == ST_ACK && sel_region == REG_LOCK && sel_write)
                locked <= 1'b1;
            // One cycle of driven-high DTACK before releasing the open-drain pin.
            dtack_rel <= (state == ST_TERM) && as_s && (sel_region != REG_NONE);
        end
    end

    logic active, we_win, lanes_any, cs_en;

    always_comb begin
        active    = (state == ST_WAIT) || (state == ST_ACK) || (state == ST_TERM);
        we_win    = (state == ST_WAIT) || (state == ST_ACK);
        lanes_any = (sel_lanes != 2'b11);
        cs_en     = 1'b0;
        rome_n    = 1'b1;
        wom_we_n  = 2'b11;
        wom_oe_n  = 1'b1;
        dtack_n   = 1'b1;
        dtack_oe  = dtack_rel;
        wom_cs_n  = '1;
        if (active && lanes_any) begin
            case (sel_region)
                REG_BOOT: if (!sel_write) rome_n = 1'b0;
                REG_WOM: begin
                    if (!sel_write && !sel_locked) begin
                        rome_n = 1'b0;
                    end else if (!sel_write) begin
                        cs_en    = 1'b1;
                        wom_oe_n = 1'b0;
                    end else if (!sel_locked && we_win) begin
                        cs_en    = 1'b1;
                        wom_we_n = sel_lanes;
                    end
                end
                default: ;
            endcase
        end
        for (int i = 0; i < WOM_BANKS; i++) begin
            if (cs_en && sel_bank == i[1:0]) wom_cs_n[i] = 1'b0;
        end
        if (state == ST_ACK || (state == ST_TERM && sel_region != REG_NONE)) begin
            dtack_n  = 1'b0;
            dtack_oe = 1'b1;
        end
    end

    assign wom_locked = locked;

    a_one_select: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({~rome_n, ~wom_cs_n}));

endmodule
